pio_edge_input: RTL

PIO_EDGE_INPUT -- requirements
Module: pio_edge_input

---
 rtl/pio_edge_input.sv | 108 ++++++++++
 1 files changed

// File: rtl/pio_edge_input.sv
// Edge-capturing parallel input port: synchronizes in_port, latches selected edges
// into a write-1-to-clear capture register and raises a maskable level interrupt.
module pio_edge_input #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] syncIn;
    logic [WIDTH-1:0] syncDelay_q;
    logic [WIDTH-1:0] edgeEvent;
    logic [WIDTH-1:0] irqMask_q, irqMask_d;
    logic [WIDTH-1:0] edgeCapture_q, edgeCapture_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             writeEn;
    logic [WIDTH-1:0] writeBits;
    logic             unusedWritedata;

    assign writeEn   = chipselect & ~write_n;
    assign writeBits = writedata[WIDTH-1:0];
    assign syncIn    = sync_q[SYNC_STAGES-1];

    // Bits above WIDTH are intentionally ignored on writes.
    assign unusedWritedata = ^writedata;

    // Pure flop chain: nothing may sit between stages or metastability settling suffers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            syncDelay_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            syncDelay_q <= syncIn;
        end
    end

    always_comb begin
        edgeEvent = '0;
        if (EDGE_TYPE == 0) begin
            edgeEvent = syncIn & ~syncDelay_q;
        end else if (EDGE_TYPE == 1) begin
            edgeEvent = ~syncIn & syncDelay_q;
        end else begin
            edgeEvent = syncIn ^ syncDelay_q;
        end
    end

    // A new edge outranks a simultaneous clear so no event is ever lost.
    always_comb begin
        irqMask_d     = irqMask_q;
        edgeCapture_d = edgeCapture_q;
        if (writeEn && address == ADDR_MASK) begin
            irqMask_d = writeBits;
        end
        if (writeEn && address == ADDR_CAPTURE) begin
            edgeCapture_d = edgeCapture_q & ~writeBits;
        end
        edgeCapture_d = edgeCapture_d | edgeEvent;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = syncIn;
            ADDR_RSVD:    readdata_d            = '0;
            ADDR_MASK:    readdata_d[WIDTH-1:0] = irqMask_q;
            ADDR_CAPTURE: readdata_d[WIDTH-1:0] = edgeCapture_q;
            default:      readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqMask_q     <= '0;
            edgeCapture_q <= '0;
            readdata_q    <= '0;
        end else begin
            irqMask_q     <= irqMask_d;
            edgeCapture_q <= edgeCapture_d;
            readdata_q    <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgeCapture_q & irqMask_q);

endmodule
